// File: rtl/npc_pkg.sv
// npc_pkg: shared NPC core definitions.
//   - Load funct3 codes used by the writeback stage and the LSU.
//   - Writeback stage state encoding (1 bit).
package npc_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// load_align: selects the byte/halfword/word of a load response and extends it.
// Ports:
//   word     - aligned 32-bit memory word
//   funct3   - load width/sign code (unknown codes behave as LW)
//   offset   - byte offset within the word (addr[1:0])
//   ext_data - extracted and sign/zero-extended data
module load_align
  import npc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [2:0]            funct3,
  input  logic [1:0]            offset,
  output logic [DATA_WIDTH-1:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    // Halfword selection ignores offset[0]: misaligned halves are not split.
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      FUNCT3_LB:  ext_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      FUNCT3_LBU: ext_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      FUNCT3_LH:  ext_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      FUNCT3_LHU: ext_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default:    ext_data = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the NPC core; drives the register file write port.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   in_valid/in_ready          - retire handshake (in_ready high only when idle)
//   in_pc/in_rd/in_rd_wen      - PC, destination index and write enable of the instruction
//   in_is_load/in_funct3       - load flag and load width/sign code
//   in_result                  - ALU result, or effective address for loads
//   lsu_rvalid/lsu_rdata       - single-cycle load response
//   rf_wen/rf_waddr/rf_wdata   - registered register-file write (one-cycle pulse)
//   commit_valid/commit_pc     - registered commit pulse and retired PC
module wb_stage
  import npc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PC_WIDTH-1:0]   in_pc,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_wen,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  lsu_rvalid,
  input  logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  commit_valid,
  output logic [PC_WIDTH-1:0]   commit_pc
);

  wb_state_e             state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                  rd_wen_q, rd_wen_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            off_q, off_d;

  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic                  commit_valid_q, commit_valid_d;
  logic [PC_WIDTH-1:0]   commit_pc_q, commit_pc_d;

  logic [DATA_WIDTH-1:0] load_data;

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .word     (lsu_rdata),
    .funct3   (funct3_q),
    .offset   (off_q),
    .ext_data (load_data)
  );

  assign in_ready = (state_q == S_IDLE);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    rd_d           = rd_q;
    rd_wen_d       = rd_wen_q;
    funct3_d       = funct3_q;
    off_d          = off_q;
    rf_wen_d       = 1'b0;
    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    commit_valid_d = 1'b0;
    commit_pc_d    = commit_pc_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (in_is_load) begin
            pc_d     = in_pc;
            rd_d     = in_rd;
            rd_wen_d = in_rd_wen;
            funct3_d = in_funct3;
            off_d    = in_result[1:0];
            state_d  = S_WAIT_LOAD;
          end else begin
            rf_wen_d       = in_rd_wen && (in_rd != '0);
            rf_waddr_d     = in_rd;
            rf_wdata_d     = in_result;
            commit_valid_d = 1'b1;
            commit_pc_d    = in_pc;
          end
        end
      end
      S_WAIT_LOAD: begin
        if (lsu_rvalid) begin
          rf_wen_d       = rd_wen_q && (rd_q != '0);
          rf_waddr_d     = rd_q;
          rf_wdata_d     = load_data;
          commit_valid_d = 1'b1;
          commit_pc_d    = pc_q;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      pc_q           <= '0;
      rd_q           <= '0;
      rd_wen_q       <= 1'b0;
      funct3_q       <= '0;
      off_q          <= '0;
      rf_wen_q       <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      rd_q           <= rd_d;
      rd_wen_q       <= rd_wen_d;
      funct3_q       <= funct3_d;
      off_q          <= off_d;
      rf_wen_q       <= rf_wen_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
    end
  end

  assign rf_wen       = rf_wen_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign commit_valid = commit_valid_q;
  assign commit_pc    = commit_pc_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed scenarios plus randomized traffic for wb_stage, checked
// every cycle against a transaction-level model of the writeback stage.
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [31:0] in_result;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        commit_valid;
  logic [31:0] commit_pc;

  wb_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .PC_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_rd        (in_rd),
    .in_rd_wen    (in_rd_wen),
    .in_is_load   (in_is_load),
    .in_funct3    (in_funct3),
    .in_result    (in_result),
    .lsu_rvalid   (lsu_rvalid),
    .lsu_rdata    (lsu_rdata),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit started = 1'b0;

  // Model: a pending-load record plus the expected registered outputs.
  bit          m_busy;
  bit          m_acc;
  logic [31:0] m_ld_pc;
  logic [4:0]  m_ld_rd;
  bit          m_ld_wen;
  logic [2:0]  m_ld_f3;
  logic [1:0]  m_ld_off;
  bit          e_wen, e_commit;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata, e_cpc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] m_extract(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] off);
    logic [31:0] b, h;
    b = (w >> (8 * int'(off))) & 32'hFF;
    h = (w >> (16 * int'(off[1]))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic void m_reset();
    m_busy = 0; m_acc = 0;
    m_ld_pc = '0; m_ld_rd = '0; m_ld_wen = 0; m_ld_f3 = '0; m_ld_off = '0;
    e_wen = 0; e_commit = 0; e_waddr = '0; e_wdata = '0; e_cpc = '0;
  endfunction

  // Applies one clock edge's worth of retire rules using the inputs held at that edge.
  function automatic void m_update();
    e_wen = 0; e_commit = 0; m_acc = 0;
    if (m_busy) begin
      if (lsu_rvalid) begin
        e_wen = m_ld_wen && (m_ld_rd != 0);
        e_waddr = m_ld_rd;
        e_wdata = m_extract(lsu_rdata, m_ld_f3, m_ld_off);
        e_commit = 1; e_cpc = m_ld_pc;
        m_busy = 0;
      end
    end else if (in_valid) begin
      m_acc = 1;
      if (in_is_load) begin
        m_busy = 1;
        m_ld_pc = in_pc; m_ld_rd = in_rd; m_ld_wen = in_rd_wen;
        m_ld_f3 = in_funct3; m_ld_off = in_result[1:0];
      end else begin
        e_wen = in_rd_wen && (in_rd != 0);
        e_waddr = in_rd; e_wdata = in_result;
        e_commit = 1; e_cpc = in_pc;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
      chk("rf_wen", {31'd0, rf_wen}, {31'd0, e_wen});
      chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, e_waddr});
      chk("rf_wdata", rf_wdata, e_wdata);
      chk("commit_valid", {31'd0, commit_valid}, {31'd0, e_commit});
      chk("commit_pc", commit_pc, e_cpc);
    end
  end

  task automatic step(input bit v, input bit ld, input logic [31:0] pc, input logic [4:0] rd,
                      input bit wen, input logic [2:0] f3, input logic [31:0] res,
                      input bit rv, input logic [31:0] rdata);
    in_valid = v; in_is_load = ld; in_pc = pc; in_rd = rd; in_rd_wen = wen;
    in_funct3 = f3; in_result = res; lsu_rvalid = rv; lsu_rdata = rdata;
    @(posedge clk);
    #1;
    if (!rst_n) m_reset();
    else m_update();
  endtask

  task automatic idle(input bit rv, input logic [31:0] rdata);
    step(0, 0, 32'h0, 5'd0, 0, 3'd0, 32'h0, rv, rdata);
  endtask

  // Load from a given byte offset, response after `lat` sampled wait cycles.
  task automatic load(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd,
                      input logic [31:0] pc, input int lat, input logic [31:0] rdata);
    step(1, 1, pc, rd, 1, f3, {28'h0001_000, 2'b00, off}, 0, 32'h0);
    for (int i = 1; i < lat; i++) begin
      idle(0, 32'h0);
      chk("ready_low_wait", {31'd0, in_ready}, 32'd0);
    end
    idle(1, rdata);
  endtask

  logic [31:0] alu_res [3];
  initial begin
    alu_res[0] = 32'h11; alu_res[1] = 32'h22; alu_res[2] = 32'h33;

    // Hand-computed pins on the model's extraction rules.
    chk("model_lb", m_extract(32'h80FF_1234, 3'd0, 2'd3), 32'hFFFF_FF80);
    chk("model_lhu", m_extract(32'h8001_7FFF, 3'd5, 2'd2), 32'h0000_8001);
    chk("model_lh", m_extract(32'h8001_7FFF, 3'd1, 2'd0), 32'h0000_7FFF);
    chk("model_lbu", m_extract(32'h8001_7FFF, 3'd4, 2'd1), 32'h0000_007F);

    rst_n = 0;
    in_valid = 0; in_is_load = 0; in_pc = '0; in_rd = '0; in_rd_wen = 0;
    in_funct3 = '0; in_result = '0; lsu_rvalid = 0; lsu_rdata = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen", {31'd0, rf_wen}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_commit", {31'd0, commit_valid}, 32'd0);
    chk("rst_cpc", commit_pc, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    started = 1;
    #2 rst_n = 1;

    // Back-to-back ALU ops.
    for (int unsigned i = 0; i < 3; i++) begin
      step(1, 0, 32'h100 + 4 * i, 5'(i + 1), 1, 3'd0, alu_res[i], 0, 32'h0);
      chk("b2b_wen", {31'd0, rf_wen}, 32'd1);
      chk("b2b_waddr", {27'd0, rf_waddr}, i + 1);
      chk("b2b_wdata", rf_wdata, alu_res[i]);
      chk("b2b_cpc", commit_pc, 32'h100 + 4 * i);
    end
    idle(0, 32'h0);
    chk("b2b_wen_drop", {31'd0, rf_wen}, 32'd0);

    // LB off=3, response 4 cycles after accept.
    load(3'd0, 2'd3, 5'd7, 32'h200, 4, 32'h80FF_1234);
    chk("lb_wen", {31'd0, rf_wen}, 32'd1);
    chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
    chk("lb_ready", {31'd0, in_ready}, 32'd1);
    load(3'd5, 2'd2, 5'd8, 32'h204, 1, 32'h8001_7FFF);
    chk("lhu_wdata", rf_wdata, 32'h0000_8001);
    load(3'd1, 2'd0, 5'd9, 32'h208, 2, 32'h8001_7FFF);
    chk("lh_wdata", rf_wdata, 32'h0000_7FFF);
    load(3'd4, 2'd1, 5'd10, 32'h20C, 1, 32'h8001_7FFF);
    chk("lbu_wdata", rf_wdata, 32'h0000_007F);

    // rd=0 still commits but does not write.
    step(1, 0, 32'h300, 5'd0, 1, 3'd0, 32'hDEAD_BEEF, 0, 32'h0);
    chk("rd0_commit", {31'd0, commit_valid}, 32'd1);
    chk("rd0_wen", {31'd0, rf_wen}, 32'd0);
    chk("rd0_wdata", rf_wdata, 32'hDEAD_BEEF);

    // Reset in the middle of a load wait.
    step(1, 1, 32'h400, 5'd5, 1, 3'd2, 32'h0000_1000, 0, 32'h0);
    idle(0, 32'h0);
    #2 rst_n = 0;
    m_reset();
    #1;
    chk("arst_wdata", rf_wdata, 32'd0);
    chk("arst_cpc", commit_pc, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    #3 rst_n = 1;
    idle(1, 32'hAAAA_5555);
    chk("arst_nowen", {31'd0, rf_wen}, 32'd0);
    chk("arst_nocommit", {31'd0, commit_valid}, 32'd0);

    // Idle rvalid ignored; LW with response on first wait cycle.
    idle(1, 32'hFFFF_FFFF);
    chk("idle_rv_commit", {31'd0, commit_valid}, 32'd0);
    step(1, 1, 32'h500, 5'd12, 1, 3'd2, 32'h0000_2003, 0, 32'h0);
    idle(1, 32'h1234_5678);
    chk("lw_wen", {31'd0, rf_wen}, 32'd1);
    chk("lw_wdata", rf_wdata, 32'h1234_5678);
    chk("lw_cpc", commit_pc, 32'h500);

    // Randomized traffic; in_* held while an offered instruction is not accepted.
    in_valid = 0;
    for (int i = 0; i < 600; i++) begin
      bit v, ld, wen, rv;
      logic [31:0] pc, res;
      logic [4:0] rd;
      logic [2:0] f3;
      if (in_valid && !m_acc) begin
        v = 1; ld = in_is_load; pc = in_pc; rd = in_rd; wen = in_rd_wen;
        f3 = in_funct3; res = in_result;
      end else begin
        v = ($urandom_range(0, 9) < 7);
        ld = $urandom_range(0, 1);
        pc = $urandom & 32'hFFFF_FFFC;
        rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        wen = ($urandom_range(0, 7) != 0);
        f3 = 3'($urandom);
        res = $urandom;
      end
      rv = ($urandom_range(0, 9) < 4);
      step(v, ld, pc, rd, wen, f3, res, rv, $urandom);
    end
    idle(0, 32'h0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
